// File: rtl/gfe_dot_acc.sv
// GF(3) dot-product accumulator: multiplies operand pairs, accumulates mod 3
// over VEC_LEN beats and emits one reduced result per vector.
module gfe_dot_acc #(
   parameter int unsigned VEC_LEN = 4,
   parameter int unsigned CNT_W   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [1:0] in_a,
   input  logic [1:0] in_b,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_data,
   output logic       out_err
);

   typedef enum logic {
      ACC,
      OUT
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [1:0]       acc;
   logic [CNT_W-1:0] cnt;
   logic             err;

   logic       beat;
   logic       last;
   logic       illegal;
   logic [1:0] a_eff;
   logic [1:0] b_eff;
   logic [2:0] prod;
   logic [2:0] sum;
   logic [1:0] r;

   assign in_ready  = (state == ACC);
   assign out_valid = (state == OUT);
   assign beat      = in_valid & in_ready;
   assign last      = (cnt == CNT_W'(VEC_LEN - 1));

   // Operand value 3 is outside GF(3): it contributes zero and flags the vector.
   always_comb begin
      illegal = (in_a == 2'd3) | (in_b == 2'd3);
      a_eff   = (in_a == 2'd3) ? 2'd0 : in_a;
      b_eff   = (in_b == 2'd3) ? 2'd0 : in_b;
      prod    = {1'b0, a_eff} * {1'b0, b_eff};
      sum     = {1'b0, acc} + prod;
      if (sum >= 3'd6) begin
         r = 2'd0;
      end else if (sum >= 3'd3) begin
         r = 2'(sum - 3'd3);
      end else begin
         r = sum[1:0];
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ACC: if (beat && last) state_next = OUT;
         OUT: if (out_ready)    state_next = ACC;
         default:               state_next = ACC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACC;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         cnt      <= '0;
         err      <= 1'b0;
         out_data <= '0;
         out_err  <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (beat) begin
                  err <= err | illegal;
                  if (last) begin
                     out_data <= r;
                     out_err  <= err | illegal;
                  end else begin
                     acc <= r;
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            OUT: begin
               if (out_ready) begin
                  acc <= '0;
                  cnt <= '0;
                  err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gfe_dot_acc.sv
// Self-checking bench for gfe_dot_acc: directed vectors plus randomized ones
// checked against an integer dot-product-mod-3 model.
module tb_gfe_dot_acc;

   localparam int VL = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_a;
   logic [1:0] in_b;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_data;
   logic       out_err;

   int n_cmp = 0;
   int n_bad = 0;

   int va [VL];
   int vb [VL];

   always #5 clk = ~clk;

   gfe_dot_acc #(.VEC_LEN(VL), .CNT_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_err  (out_err)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int model_dot();
      int s = 0;
      for (int i = 0; i < VL; i++) begin
         s += ((va[i] == 3) ? 0 : va[i]) * ((vb[i] == 3) ? 0 : vb[i]);
      end
      return s % 3;
   endfunction

   function automatic int model_err();
      for (int i = 0; i < VL; i++) begin
         if (va[i] == 3 || vb[i] == 3) return 1;
      end
      return 0;
   endfunction

   task automatic idle_cycle();
      in_valid  = 1'b0;
      in_a      = 2'($urandom_range(0, 3));
      in_b      = 2'($urandom_range(0, 3));
      @(posedge clk);
      @(negedge clk);
   endtask

   // Runs one vector from va/vb; called and returns at a negedge.
   task automatic run_vector(input string tag, input int gap_pos, input int hold);
      int exp_d;
      int exp_e;
      exp_d = model_dot();
      exp_e = model_err();
      for (int i = 0; i < VL; i++) begin
         if (i == gap_pos) idle_cycle();
         check({tag, ".in_ready"}, int'(in_ready), 1);
         check({tag, ".out_valid_acc"}, int'(out_valid), 0);
         in_valid  = 1'b1;
         in_a      = 2'(va[i]);
         in_b      = 2'(vb[i]);
         out_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = (hold == 0);
      check({tag, ".out_valid"}, int'(out_valid), 1);
      check({tag, ".in_ready_out"}, int'(in_ready), 0);
      check({tag, ".out_data"}, int'(out_data), exp_d);
      check({tag, ".out_err"}, int'(out_err), exp_e);
      for (int k = 0; k < hold; k++) begin
         out_ready = 1'b0;
         in_valid  = 1'b1;
         in_a      = 2'($urandom_range(0, 3));
         in_b      = 2'($urandom_range(0, 3));
         @(posedge clk);
         @(negedge clk);
         check({tag, ".hold_valid"}, int'(out_valid), 1);
         check({tag, ".hold_ready"}, int'(in_ready), 0);
         check({tag, ".hold_data"}, int'(out_data), exp_d);
         check({tag, ".hold_err"}, int'(out_err), exp_e);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({tag, ".done_valid"}, int'(out_valid), 0);
      check({tag, ".done_ready"}, int'(in_ready), 1);
      check({tag, ".kept_data"}, int'(out_data), exp_d);
      check({tag, ".kept_err"}, int'(out_err), exp_e);
   endtask

   task automatic set_vec(input int a0, b0, a1, b1, a2, b2, a3, b3);
      va[0] = a0; vb[0] = b0; va[1] = a1; vb[1] = b1;
      va[2] = a2; vb[2] = b2; va[3] = a3; vb[3] = b3;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = 2'd0;
      in_b      = 2'd0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst.in_ready", int'(in_ready), 1);
      check("rst.out_valid", int'(out_valid), 0);
      check("rst.out_data", int'(out_data), 0);
      check("rst.out_err", int'(out_err), 0);

      set_vec(1, 2, 2, 2, 2, 1, 0, 1);  run_vector("basic", -1, 0);
      set_vec(2, 2, 2, 2, 2, 2, 2, 2);  run_vector("all22", -1, 0);
      set_vec(0, 2, 0, 1, 0, 3, 0, 2);  run_vector("zeros", -1, 0);
      set_vec(1, 1, 1, 1, 1, 1, 0, 0);  run_vector("sum3", -1, 0);
      set_vec(2, 1, 1, 2, 2, 2, 1, 1);  run_vector("bp", -1, 3);
      set_vec(1, 1, 3, 2, 1, 1, 1, 1);  run_vector("illegal", -1, 0);
      set_vec(1, 1, 1, 1, 1, 1, 1, 1);  run_vector("clean", -1, 0);

      // Reset partway through a vector; stale acc would turn 0 into 2.
      in_valid = 1'b1; in_a = 2'd2; in_b = 2'd2;
      repeat (2) begin @(posedge clk); @(negedge clk); end
      rst = 1'b1; in_a = 2'd3; in_b = 2'd3;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      check("mrst.in_ready", int'(in_ready), 1);
      check("mrst.out_valid", int'(out_valid), 0);
      set_vec(1, 1, 1, 0, 0, 0, 1, 2);  run_vector("mrst", -1, 0);

      set_vec(2, 2, 1, 2, 2, 0, 1, 1);  run_vector("b2b0", 1, 0);
      set_vec(2, 1, 2, 2, 1, 0, 2, 2);  run_vector("b2b1", 1, 0);

      for (int v = 0; v < 40; v++) begin
         for (int i = 0; i < VL; i++) begin
            va[i] = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            vb[i] = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         end
         run_vector("rand", $urandom_range(0, VL), $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
